// File: rtl/serial_tx_scheduler.sv
// Round-robin scheduler that grants one of NUM_REQ requesters and serializes
// its DATA_W-bit word LSB first, with first/last framing strobes.
module serial_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_en_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      serial_o,
  output logic                      valid_o,
  output logic [SRC_W-1:0]          src_o,
  output logic                      first_o,
  output logic                      last_o,
  output logic                      empty_o
);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_shift;
  logic [CNT_W-1:0]    r_cnt;
  logic [SRC_W-1:0]    r_src;
  logic [SRC_W-1:0]    r_last_grant;

  logic [NUM_REQ-1:0]  w_req;
  logic [NUM_REQ-1:0]  w_grant;
  logic [SRC_W-1:0]    w_grant_idx;
  logic                w_found;
  logic                w_hs;
  logic [DATA_W-1:0]   w_sel_data;
  int                  w_scan;

  assign w_req = req_valid_i & req_en_i;

  // Round-robin search starting one past the last accepted requester.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    w_scan      = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_scan = (int'(r_last_grant) + i) % NUM_REQ;
      if (!w_found && w_req[w_scan]) begin
        w_found     = 1'b1;
        w_grant_idx = SRC_W'(w_scan);
      end
    end
    w_grant[w_grant_idx] = w_found;
  end

  // Handshake: requester k transfers on a rising edge where req_valid_i[k] and
  // req_ready_o[k] are both high; ready is offered only in IDLE, only to the
  // winner, and never while reset is asserted. Nothing is latched otherwise.
  assign req_ready_o = ((r_state == ST_IDLE) && reset_n) ? w_grant : '0;
  assign w_hs        = (r_state == ST_IDLE) && w_found;
  assign w_sel_data  = req_data_i[w_grant_idx*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    valid_o     = 1'b0;
    serial_o    = 1'b0;
    first_o     = 1'b0;
    last_o      = 1'b0;
    empty_o     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        empty_o = 1'b1;
        if (w_hs) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        valid_o  = 1'b1;
        serial_o = r_shift[0];
        first_o  = (r_cnt == CNT_W'(DATA_W));
        last_o   = (r_cnt == CNT_W'(1));
        if (r_cnt == CNT_W'(1)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // last_grant resets to the top index so requester 0 is searched first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift      <= '0;
      r_cnt        <= '0;
      r_src        <= '0;
      r_last_grant <= SRC_W'(NUM_REQ - 1);
    end else if (w_hs) begin
      r_shift      <= w_sel_data;
      r_cnt        <= CNT_W'(DATA_W);
      r_src        <= w_grant_idx;
      r_last_grant <= w_grant_idx;
    end else if (r_state == ST_SHIFT) begin
      r_shift <= r_shift >> 1;
      r_cnt   <= r_cnt - CNT_W'(1);
    end
  end

  assign src_o = r_src;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Directed bench for serial_tx_scheduler: arbitration order, framing, masking,
// data capture, mid-frame reset and idle behaviour.
module tb_serial_tx_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 4;

  logic                      clk;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_en_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      serial_o;
  logic                      valid_o;
  logic [1:0]                src_o;
  logic                      first_o;
  logic                      last_o;
  logic                      empty_o;

  int n_vec = 0;
  int n_err = 0;
  logic [0:0] exp_q[$];

  serial_tx_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_en_i    (req_en_i),
    .req_ready_o (req_ready_o),
    .serial_o    (serial_o),
    .valid_o     (valid_o),
    .src_o       (src_o),
    .first_o     (first_o),
    .last_o      (last_o),
    .empty_o     (empty_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver tasks; every task returns at a falling edge with inputs settled.
  task automatic apply_reset();
    @(negedge clk);
    reset_n     = 1'b0;
    req_valid_i = '0;
    req_en_i    = '0;
    req_data_i  = '0;
    #1;
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_empty", empty_o, 1'b1);
    chk("rst_serial", serial_o, 1'b0);
    chk("rst_first_last", {first_o, last_o}, 2'b00);
    chk("rst_src", src_o, 2'd0);
    chk("rst_ready", req_ready_o, 4'b0000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Called at the falling edge just after the handshake edge; returns at the
  // falling edge of the idle cycle that follows the frame.
  task automatic expect_frame(input int src, input logic [3:0] data);
    for (int b = 0; b < DATA_W; b++) exp_q.push_back(data[b]);
    for (int b = 0; b < DATA_W; b++) begin
      chk("frm_valid", valid_o, 1'b1);
      chk("frm_serial", serial_o, exp_q.pop_front());
      chk("frm_first", first_o, (b == 0));
      chk("frm_last", last_o, (b == DATA_W - 1));
      chk("frm_src", src_o, src);
      chk("frm_ready", req_ready_o, 4'b0000);
      chk("frm_empty", empty_o, 1'b0);
      @(negedge clk);
    end
    chk("gap_valid", valid_o, 1'b0);
    chk("gap_empty", empty_o, 1'b1);
  endtask

  initial begin
    reset_n     = 1'b0;
    req_valid_i = '0;
    req_en_i    = '0;
    req_data_i  = '0;

    // Single requester
    apply_reset();
    req_valid_i = 4'b0001;
    req_en_i    = 4'b1111;
    req_data_i  = {4'h0, 4'h0, 4'h0, 4'b1011};
    #1 chk("single_ready", req_ready_o, 4'b0001);
    @(negedge clk);
    req_valid_i = '0;
    expect_frame(0, 4'b1011);

    // Fairness: all valid, grants 0,1,2,3,0
    apply_reset();
    req_valid_i = 4'b1111;
    req_en_i    = 4'b1111;
    req_data_i  = {4'h4, 4'h3, 4'h2, 4'h1};
    for (int k = 0; k < 5; k++) begin
      #1 chk("rr_ready", req_ready_o, 4'b0001 << (k % 4));
      @(negedge clk);
      expect_frame(k % 4, 4'((k % 4) + 1));
    end

    // Masking: only 0 and 2 enabled
    apply_reset();
    req_valid_i = 4'b1111;
    req_en_i    = 4'b0101;
    req_data_i  = {4'h4, 4'h3, 4'h2, 4'h1};
    for (int k = 0; k < 4; k++) begin
      #1 chk("mask_ready", req_ready_o, (k % 2 == 0) ? 4'b0001 : 4'b0100);
      @(negedge clk);
      expect_frame((k % 2 == 0) ? 0 : 2, (k % 2 == 0) ? 4'h1 : 4'h3);
    end

    // Data captured only at handshake
    apply_reset();
    req_valid_i = 4'b0100;
    req_en_i    = 4'b1111;
    req_data_i  = {4'h0, 4'hA, 4'h0, 4'h0};
    #1 chk("stab_ready", req_ready_o, 4'b0100);
    @(negedge clk);
    req_data_i[11:8] = 4'h5;
    req_valid_i      = '0;
    expect_frame(2, 4'hA);

    // Mid-frame reset during bit1 of requester 1's frame
    apply_reset();
    req_valid_i = 4'b0111;
    req_en_i    = 4'b1111;
    req_data_i  = {4'h0, 4'h0, 4'h6, 4'b1011};
    #1 chk("mr_ready0", req_ready_o, 4'b0001);
    @(negedge clk);
    expect_frame(0, 4'b1011);
    chk("mr_ready1", req_ready_o, 4'b0010);
    @(negedge clk);
    chk("mr_bit0", serial_o, 1'b0);
    @(negedge clk);
    chk("mr_bit1_valid", valid_o, 1'b1);
    chk("mr_bit1", serial_o, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mr_async_valid", valid_o, 1'b0);
    chk("mr_async_empty", empty_o, 1'b1);
    chk("mr_async_ready", req_ready_o, 4'b0000);
    chk("mr_async_serial", serial_o, 1'b0);
    chk("mr_async_src", src_o, 2'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("mr_hold_valid", valid_o, 1'b0);
      chk("mr_hold_ready", req_ready_o, 4'b0000);
    end
    reset_n = 1'b1;
    #1 chk("mr_post_ready", req_ready_o, 4'b0001);
    @(negedge clk);
    chk("mr_post_src", src_o, 2'd0);
    chk("mr_post_first", first_o, 1'b1);
    chk("mr_post_serial", serial_o, 1'b1);
    req_valid_i = '0;
    repeat (4) @(negedge clk);
    chk("mr_post_empty", empty_o, 1'b1);

    // Idle for 20 cycles; last_grant stays at 0
    for (int c = 0; c < 20; c++) begin
      chk("idle_ready", req_ready_o, 4'b0000);
      chk("idle_valid", valid_o, 1'b0);
      chk("idle_empty", empty_o, 1'b1);
      @(negedge clk);
    end

    // Withdrawal before the edge leaves nothing latched
    req_valid_i = 4'b0001;
    #1 chk("wd_ready", req_ready_o, 4'b0001);
    req_valid_i = '0;
    #1 chk("wd_ready_drop", req_ready_o, 4'b0000);
    @(negedge clk);
    chk("wd_empty", empty_o, 1'b1);
    chk("wd_valid", valid_o, 1'b0);

    req_valid_i = 4'b1111;
    #1 chk("idle_rr_ready", req_ready_o, 4'b0010);
    @(negedge clk);
    req_valid_i = '0;
    chk("idle_rr_src", src_o, 2'd1);
    chk("idle_rr_first", first_o, 1'b1);
    repeat (4) @(negedge clk);
    chk("final_empty", empty_o, 1'b1);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_tx_scheduler.md
SERIAL_TX_SCHEDULER -- requirements
Module: serial_tx_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the serializer.
REQ-002 Parameter DATA_W, default 4: nibble width, bits per serial frame.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid_i  input  NUM_REQ  per-requester data-valid.
REQ-006 req_data_i  input  NUM_REQ*DATA_W  packed data; requester k occupies bits [k*DATA_W +: DATA_W].
REQ-007 req_en_i  input  NUM_REQ  per-requester enable mask; a 0 excludes that requester from arbitration.
REQ-008 req_ready_o  output  NUM_REQ  one-hot grant/accept, or all-zero.
REQ-009 serial_o  output  1  serial data, LSB first.
REQ-010 valid_o  output  1  high while serial_o carries a frame bit.
REQ-011 src_o  output  clog2(NUM_REQ)  index of the requester owning the current frame.
REQ-012 first_o / last_o  output  1 each  high on the first / last bit of a frame.
REQ-013 empty_o  output  1  high when no frame is in flight (state IDLE).

Function
REQ-014 FSM has two states: IDLE and SHIFT.
REQ-015 In IDLE, req_ready_o SHALL combinationally assert the single bit of the winning requester among those with req_valid_i & req_en_i; the bit is 0 for all others.
REQ-016 If no requester has req_valid_i & req_en_i, req_ready_o SHALL be all-zero.
REQ-017 Arbitration SHALL be round-robin: search starts at last_grant+1 and wraps from NUM_REQ-1 to 0.
REQ-018 last_grant SHALL update only on an accepted handshake.
REQ-019 A handshake is req_valid_i[k] & req_ready_o[k] in IDLE; on that edge, load the shift register with requester k's data, set src_o=k, bit counter=DATA_W, and go to SHIFT.
REQ-020 Data SHALL be sampled only at the handshake edge; req_data_i changes at other times have no effect.
REQ-021 In SHIFT:
  - req_ready_o = 0.
  - valid_o = 1.
  - serial_o = shift_reg[0].
  - Each edge: logical right shift and counter decrement.
REQ-022 first_o SHALL be high in the first SHIFT cycle (counter==DATA_W); last_o SHALL be high when counter==1.
REQ-023 When counter==1, the next edge SHALL return to IDLE.
REQ-024 Latency: handshake edge N gives bit0 in cycle N+1 and bit DATA_W-1 in cycle N+DATA_W. At least one IDLE cycle (valid_o=0) separates frames, so one frame completes per DATA_W+1 cycles.
REQ-025 Outside SHIFT: valid_o, first_o, last_o = 0; serial_o = 0; src_o holds its last value.
REQ-026 empty_o SHALL equal (state==IDLE).
REQ-027 Withdrawal: a requester may drop req_valid_i or req_en_i at any time before its handshake; no request is latched or queued.
REQ-028 Changes to req_en_i during SHIFT SHALL NOT affect the frame in flight.
REQ-029 Ties are impossible: at most one req_ready_o bit is high in any cycle.

Reset
REQ-030 On reset_n low, asynchronously and independent of clk:
  - state=IDLE, shift register=0, counter=0, src_o=0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
  - serial_o, valid_o, first_o, last_o = 0; empty_o = 1.
REQ-031 While reset_n is low, req_ready_o SHALL be all-zero.
REQ-032 Reset asserted mid-frame SHALL abort the frame; no remaining bits are emitted after release.
REQ-033 The first handshake SHALL occur no earlier than the first rising edge after reset_n rises.

Verification
REQ-034 Single requester: req0 data=4'b1011, en=1111 -> ready_o=0001 in IDLE; then serial 1,1,0,1 with valid=1, src=0, first on bit0, last on bit3; then one cycle valid=0.
REQ-035 Fairness: all four requesters valid continuously with data 1,2,3,4 -> grants in order 0,1,2,3,0; frames every 5 cycles; src_o matches the grant order.
REQ-036 Masking: req_valid=1111, req_en=0101 -> only requesters 0 and 2 are granted, alternating; ready bits 1 and 3 never assert.
REQ-037 Data stability: change req2_data from 4'hA to 4'h5 one cycle after its handshake -> serial output still 0,1,0,1 (4'hA).
REQ-038 Mid-frame reset: assert reset_n=0 during bit1 -> valid_o=0, empty_o=1, req_ready_o=0 immediately without a clock edge; after release, req0 wins first arbitration.
REQ-039 Idle: all req_valid=0 for 20 cycles -> ready_o=0, valid_o=0, empty_o=1 throughout; last_grant unchanged.
